// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner/select sequencer for a shared 4:1 datapath mux.
// An owner keeps the grant while requesting, with a bounded burst when others wait.
//
// state | meaning
// IDLE  | no owner; grant_o=0, select_o keeps the last owner
// GRANT | owner holds the resource; hold counter tracks the burst length
module mux4_rr_arbiter #(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [3:0]       req_i,
  output logic [3:0]       grant_o,
  output logic [1:0]       select_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] hold_cnt_o
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  state_t           r_state;
  logic [1:0]       r_owner;
  logic [1:0]       r_ptr;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [3:0]       r_grant;
  logic             r_valid;

  logic [1:0]       w_idle_win;
  logic [1:0]       w_rot_win;
  logic             w_owner_req;
  logic             w_others;
  logic             w_hold_last;

  // First requester after 'from' in circular order; 'from' itself is checked last.
  function automatic logic [1:0] rr_pick(input logic [1:0] from, input logic [3:0] req);
    logic [1:0] c;
    rr_pick = from;
    for (int k = 4; k >= 1; k--) begin
      c = from + 2'(k);
      if (req[c]) rr_pick = c;
    end
  endfunction

  assign w_idle_win  = rr_pick(r_ptr, req_i);
  assign w_rot_win   = rr_pick(r_owner, req_i);
  assign w_owner_req = req_i[r_owner];
  assign w_others    = |(req_i & ~(4'b0001 << r_owner));
  assign w_hold_last = (r_hold_cnt == HOLD_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_owner    <= 2'd0;
      r_ptr      <= 2'd3;
      r_hold_cnt <= '0;
      r_grant    <= 4'b0000;
      r_valid    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|req_i) begin
            r_state    <= GRANT;
            r_owner    <= w_idle_win;
            r_hold_cnt <= '0;
            r_grant    <= 4'b0001 << w_idle_win;
            r_valid    <= 1'b1;
          end
        end
        GRANT: begin
          if (!w_owner_req) begin
            r_ptr <= r_owner;
            if (w_others) begin
              // back-to-back handover, no idle bubble
              r_owner    <= w_rot_win;
              r_hold_cnt <= '0;
              r_grant    <= 4'b0001 << w_rot_win;
            end else begin
              r_state <= IDLE;
              r_grant <= 4'b0000;
              r_valid <= 1'b0;
            end
          end else if (w_hold_last) begin
            r_hold_cnt <= '0;
            if (w_others) begin
              r_ptr   <= r_owner;
              r_owner <= w_rot_win;
              r_grant <= 4'b0001 << w_rot_win;
            end
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= 4'b0000;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign grant_o    = r_grant;
  assign select_o   = r_owner;
  assign valid_o    = r_valid;
  assign hold_cnt_o = r_hold_cnt;

endmodule
